// File: rtl/fpu_pkg.sv
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared FPU format definitions (field widths, bias, status codes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    localparam int FPU_SIGN_W   = 1;
    localparam int FPU_EXP_W    = 10;
    localparam int FPU_MANT_W   = 21;
    localparam int FPU_WORD_W   = FPU_SIGN_W + FPU_EXP_W + FPU_MANT_W;
    localparam int FPU_EXP_BIAS = 511;

    typedef enum logic [1:0] {
        OVERFLOW  = 2'd0,
        UNDERFLOW = 2'd1,
        EXACT     = 2'd2,
        INEXACT   = 2'd3
    } status_t;

endpackage : fpu_pkg

`default_nettype wire

// File: rtl/int_to_fp.sv
// ============================================================================
// Module   : int_to_fp
// Purpose  : Converts a signed 32-bit integer to the FPU float format using
//            iterative one-bit-per-cycle normalization; truncates, no rounding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_to_fp
    import fpu_pkg::*;
#(
    parameter int EXP_BIAS = FPU_EXP_BIAS,
    parameter int INT_W    = 32
) (
    input  logic                  clock_100Khz,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INT_W-1:0]      int_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FPU_WORD_W-1:0] data_out,
    output status_t               status_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } conv_state_t;

    // Exponent of a magnitude whose MSB already sits in bit INT_W-1.
    localparam logic [FPU_EXP_W-1:0] C_EXP_INIT = FPU_EXP_W'(EXP_BIAS + INT_W - 1);
    localparam int                   C_LOW_W    = INT_W - 1 - FPU_MANT_W;

    conv_state_t          r_state;
    logic [INT_W-1:0]     r_int;
    logic                 r_sign;
    logic [INT_W-1:0]     r_mag;
    logic [FPU_EXP_W-1:0] r_exp;
    logic [INT_W-1:0]     w_abs;

    // -2^31 maps to itself, which reads correctly as an unsigned magnitude.
    assign w_abs    = r_int[INT_W-1] ? ((~r_int) + {{(INT_W-1){1'b0}}, 1'b1}) : r_int;
    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            r_state    <= IDLE;
            r_int      <= '0;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_exp      <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            status_out <= EXACT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_int   <= int_in;
                        r_state <= ABS;
                    end
                end
                ABS: begin
                    r_sign  <= r_int[INT_W-1];
                    r_mag   <= w_abs;
                    r_exp   <= C_EXP_INIT;
                    r_state <= (w_abs == '0) ? PACK : NORM;
                end
                NORM: begin
                    if (!r_mag[INT_W-1]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - {{(FPU_EXP_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_state <= PACK;
                    end
                end
                PACK: begin
                    if (r_mag == '0) begin
                        data_out   <= '0;
                        status_out <= EXACT;
                    end else begin
                        data_out   <= {r_sign, r_exp, r_mag[INT_W-2 -: FPU_MANT_W]};
                        status_out <= (r_mag[C_LOW_W-1:0] != '0) ? INEXACT : EXACT;
                    end
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule : int_to_fp

`default_nettype wire

// File: doc/int_to_fp.md
INT_TO_FP -- requirements
Module: int_to_fp

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 511, giving the exponent bias of the 32-bit FPU format {sign[31], exp[30:21], mant[20:0]}.
REQ-002 SHALL have parameter INT_W, default 32, giving the input integer width; only 32 is supported.
REQ-003 clock_100Khz  input  1  the only clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  int_in holds a valid operand.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 int_in  input  32  two's-complement signed integer.
REQ-008 out_valid  output  1  data_out and status_out are valid.
REQ-009 out_ready  input  1  consumer (FPU operand register) takes the result.
REQ-010 data_out  output  32  converted value in FPU format.
REQ-011 status_out  output  status_t  EXACT or INEXACT.

Function
REQ-012 SHALL implement FSM states IDLE, ABS, NORM, PACK, DONE.
REQ-013 in_ready SHALL equal (state==IDLE); acceptance occurs on an edge with in_valid && in_ready; the transition is IDLE->ABS and int_in is captured.
REQ-014 ABS SHALL store sign=int_in[31] and mag=|int_in| as 32-bit unsigned (so -2^31 gives 0x80000000), and SHALL set exp=EXP_BIAS+31 (542).
REQ-015 ABS SHALL go to PACK if mag==0, else to NORM.
REQ-016 NORM SHALL, per cycle, if mag[31]==0, shift mag left 1 and decrement exp; else go to PACK.
REQ-017 PACK SHALL set data_out={sign, exp[9:0], mag[30:10]} with truncation, no rounding.
REQ-018 PACK SHALL set status_out=INEXACT if mag[9:0]!=0, else EXACT.
REQ-019 PACK SHALL set out_valid=1 and go to DONE.
REQ-020 For zero input, PACK SHALL output data_out=0x00000000, sign forced 0, status EXACT.
REQ-021 Latency from the accept edge to out_valid high SHALL be k+3 cycles, where k = leading zeros of mag (0..31), and 2 cycles for zero.
REQ-022 In DONE, data_out, status_out and out_valid SHALL hold stable while out_ready==0.
REQ-023 On an edge with out_valid && out_ready, the block SHALL clear out_valid and go to IDLE; in_ready rises the next cycle, with no same-cycle accept.
REQ-024 in_valid while not in IDLE SHALL be ignored, and int_in changes mid-conversion SHALL not affect the result.
REQ-025 OVERFLOW and UNDERFLOW SHALL never be produced, since every int32 fits the exponent range.
REQ-026 Any unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-027 While reset==1 at an edge, the block SHALL set state=IDLE, out_valid=0, data_out=0, status_out=EXACT, and clear all internal registers.
REQ-028 Reset asserted mid-conversion or in DONE SHALL abandon the operation, with no out_valid afterwards.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 status_t {OVERFLOW, UNDERFLOW, EXACT, INEXACT}, the FPU field widths (1/10/21) and the default bias 511 SHALL live in shared package fpu_pkg, used by this block and the FPU.
REQ-031 The FSM state typedef SHALL be local to int_to_fp, so its names do not clash with the FPU state_t.
REQ-032 No sub-module SHALL be used, since normalization is iterative in-block.

Verification
REQ-033 int_in=1 -> data_out=0x3FE00000, EXACT, out_valid 34 cycles after accept.
REQ-034 int_in=0xFFFFFFFF (-1) -> data_out=0xBFE00000, EXACT; int_in=0 -> data_out=0x00000000, EXACT, latency 2.
REQ-035 int_in=0x80000000 -> data_out=0xC3C00000, EXACT, latency 3.
REQ-036 int_in=0x7FFFFFFF -> data_out=0x43BFFFFF, INEXACT, latency 4.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a new in_valid is ignored; pulse out_ready -> IDLE, next operand accepted.
REQ-038 Reset pulse during NORM for int_in=1 -> out_valid stays 0, data_out=0, in_ready=1 after release.
